dpu_ctrl_sequencer: RTL and testbench

- Microcode sequencer directly upstream of the frame-memory processing unit (FRAM PU).
- Stores a short program of control words and replays it to drive the PU control inputs: address, write strobe, output enable.
- Replaces hand-written per-cycle control stimulus; used both in silicon and as a reusable bench driver.
- Program is loaded through a simple write port, then started, paused, aborted or looped by host handshakes.

---
 rtl/dpu_ctrl_sequencer_if.sv | 35 +++
 rtl/dpu_ctrl_sequencer.sv | 150 +++++++++++++++
 tb/tb_dpu_ctrl_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dpu_ctrl_sequencer_if.sv
// Host/PU-facing bundle of the control-word sequencer: program write port,
// run-control handshakes and the PU control outputs.
interface dpu_ctrl_sequencer_if #(
    parameter int AW    = 4,
    parameter int RW    = 4,
    parameter int DEPTH = 16
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W  = AW + RW + 3;

    logic          prog_we;
    logic [PW-1:0] prog_addr;
    logic [W-1:0]  prog_data;
    logic          start;
    logic          loop_en;
    logic          pause;
    logic          abort;
    logic [AW-1:0] dp_addr;
    logic          dp_wr;
    logic          dp_oe;
    logic          busy;
    logic          done;
    logic [PW-1:0] pc;
    logic          prog_err;

    modport master (
        output prog_we, prog_addr, prog_data, start, loop_en, pause, abort,
        input  dp_addr, dp_wr, dp_oe, busy, done, pc, prog_err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, loop_en, pause, abort,
        output dp_addr, dp_wr, dp_oe, busy, done, pc, prog_err
    );
endinterface

// File: rtl/dpu_ctrl_sequencer.sv
// Microcode sequencer: replays a stored program of {last, rep, oe, wr, addr}
// control words onto the FRAM PU control inputs.
module dpu_ctrl_sequencer #(
    parameter int AW    = 4,
    parameter int RW    = 4,
    parameter int DEPTH = 16
) (
    input  logic                 dp_clk,
    input  logic                 dp_rst_n,
    dpu_ctrl_sequencer_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W  = AW + RW + 3;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] pc, pc_nxt, pc_inc, load_idx;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic          wr_q, wr_nxt, oe_q, oe_nxt, last_q, last_nxt;
    logic          dp_wr_q, dp_wr_nxt, busy_q, done_q, done_nxt, err_q, err_nxt;
    logic [W-1:0]  word;
    logic          finish;

    // Only one word can ever be fetched next: word 0 on start or loop,
    // otherwise the successor of pc (wrapping past the top of memory).
    assign pc_inc   = (pc == PW'(DEPTH - 1)) ? '0 : pc + PW'(1);
    assign load_idx = (state == RUN && !last_q) ? pc_inc : '0;
    assign word     = mem[load_idx];
    assign finish   = (state == RUN) && (rep_cnt == '0) && last_q && !bus.loop_en;

    always_ff @(posedge dp_clk) begin
        if (bus.prog_we && state == IDLE)
            mem[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge dp_clk or negedge dp_rst_n) begin
        if (!dp_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_nxt = RUN;
                RUN:     if (finish) state_nxt = IDLE;
                         else if (bus.pause) state_nxt = PAUSE;
                PAUSE:   if (!bus.pause) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Every edge that ends a RUN cycle consumes one step, even the one that
    // enters PAUSE, so a word occupies exactly rep+1 RUN cycles.
    always_comb begin
        pc_nxt    = pc;
        rep_nxt   = rep_cnt;
        addr_nxt  = addr_q;
        wr_nxt    = wr_q;
        oe_nxt    = oe_q;
        last_nxt  = last_q;
        done_nxt  = 1'b0;
        err_nxt   = err_q | (bus.prog_we && state != IDLE);
        if (bus.abort) begin
            pc_nxt   = '0;
            rep_nxt  = '0;
            addr_nxt = '0;
            wr_nxt   = 1'b0;
            oe_nxt   = 1'b0;
            last_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pc_nxt   = '0;
                        rep_nxt  = word[AW+RW+1:AW+2];
                        addr_nxt = word[AW-1:0];
                        wr_nxt   = word[AW];
                        oe_nxt   = word[AW+1];
                        last_nxt = word[W-1];
                        err_nxt  = 1'b0;
                    end
                end
                RUN: begin
                    if (rep_cnt != '0) begin
                        rep_nxt = rep_cnt - RW'(1);
                    end else if (finish) begin
                        pc_nxt   = '0;
                        addr_nxt = '0;
                        wr_nxt   = 1'b0;
                        oe_nxt   = 1'b0;
                        last_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        pc_nxt   = load_idx;
                        rep_nxt  = word[AW+RW+1:AW+2];
                        addr_nxt = word[AW-1:0];
                        wr_nxt   = word[AW];
                        oe_nxt   = word[AW+1];
                        last_nxt = word[W-1];
                    end
                end
                default: ;
            endcase
        end
        dp_wr_nxt = (state_nxt == RUN) && wr_nxt;
    end

    always_ff @(posedge dp_clk or negedge dp_rst_n) begin
        if (!dp_rst_n) begin
            pc      <= '0;
            rep_cnt <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            oe_q    <= 1'b0;
            last_q  <= 1'b0;
            dp_wr_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            rep_cnt <= rep_nxt;
            addr_q  <= addr_nxt;
            wr_q    <= wr_nxt;
            oe_q    <= oe_nxt;
            last_q  <= last_nxt;
            dp_wr_q <= dp_wr_nxt;
            busy_q  <= (state_nxt != IDLE);
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    assign bus.dp_addr  = addr_q;
    assign bus.dp_wr    = dp_wr_q;
    assign bus.dp_oe    = oe_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pc       = pc;
    assign bus.prog_err = err_q;
endmodule

// File: tb/tb_dpu_ctrl_sequencer.sv
// Directed bench for dpu_ctrl_sequencer: expected output vectors are queued as
// stimulus is driven and popped one per cycle against the DUT.
module tb_dpu_ctrl_sequencer;
    localparam int AW = 4, RW = 4, DEPTH = 16, PW = 4, W = 11, EW = 13;
    localparam logic [7:0] PU_WDATA = 8'hA5;

    typedef struct {
        string         tag;
        logic [EW-1:0] vec;
    } exp_t;

    logic       dp_clk = 1'b0;
    logic       dp_rst_n;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] fram [16];
    logic [7:0] dp_value;

    dpu_ctrl_sequencer_if #(.AW(AW), .RW(RW), .DEPTH(DEPTH)) bus();

    dpu_ctrl_sequencer #(.AW(AW), .RW(RW), .DEPTH(DEPTH)) dut (
        .dp_clk   (dp_clk),
        .dp_rst_n (dp_rst_n),
        .bus      (bus)
    );

    always #5 dp_clk = ~dp_clk;

    // Minimal FRAM PU model fed by the sequencer's control outputs
    always @(posedge dp_clk) begin
        if (bus.dp_wr) fram[bus.dp_addr] = PU_WDATA;
    end
    assign dp_value = bus.dp_oe ? fram[bus.dp_addr] : 8'h00;

    function automatic logic [W-1:0] mkWord(logic last, logic [RW-1:0] rep, logic oe, logic wr,
                                           logic [AW-1:0] addr);
        return {last, rep, oe, wr, addr};
    endfunction

    function automatic void pushExp(string tag, logic [AW-1:0] addr, logic wr, logic oe,
                                    logic busy, logic done, logic [PW-1:0] pc, logic err);
        sb.push_back('{tag: tag, vec: {addr, wr, oe, busy, done, pc, err}});
    endfunction

    task automatic applyStimulus(logic s, logic p, logic a);
        bus.start = s;
        bus.pause = p;
        bus.abort = a;
    endtask

    task automatic compareNow();
        exp_t          e;
        logic [EW-1:0] obs;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL sb_empty observed=output expected=queued entry");
            return;
        end
        e   = sb.pop_front();
        obs = {bus.dp_addr, bus.dp_wr, bus.dp_oe, bus.busy, bus.done, bus.pc, bus.prog_err};
        checks++;
        assert (obs === e.vec) else begin
            errors++;
            $error("[TB] FAIL %s observed={addr,wr,oe,busy,done,pc,err}=%b expected=%b",
                   e.tag, obs, e.vec);
        end
    endtask

    task automatic checkOutput();
        @(posedge dp_clk);
        #1;
        compareNow();
    endtask

    task automatic checkValue(string tag, logic [7:0] exp);
        checks++;
        assert (dp_value === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed dp_value=%h expected=%h", tag, dp_value, exp);
        end
    endtask

    task automatic writeWord(logic [PW-1:0] a, logic [W-1:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        @(posedge dp_clk);
        #1;
        bus.prog_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=no finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) fram[i] = 8'h00;
        dp_rst_n      = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.loop_en   = 1'b0;
        applyStimulus(1, 0, 0);

        // Reset held with start high, then idle until a fresh start
        pushExp("rst0", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        pushExp("rst1", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        dp_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pushExp("idle_after_rst", 0, 0, 0, 0, 0, 0, 0);
            checkOutput();
        end

        // Single-pass write then read back through the PU model
        writeWord(0, mkWord(0, 0, 0, 1, 3));
        writeWord(1, mkWord(0, 1, 1, 0, 3));
        writeWord(2, mkWord(1, 0, 1, 0, 5));
        applyStimulus(1, 0, 0);
        pushExp("sp_w0", 3, 1, 0, 1, 0, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        pushExp("sp_w1a", 3, 0, 1, 1, 0, 1, 0);
        pushExp("sp_w1b", 3, 0, 1, 1, 0, 1, 0);
        pushExp("sp_w2", 5, 0, 1, 1, 0, 2, 0);
        pushExp("sp_done", 0, 0, 0, 0, 1, 0, 0);
        pushExp("sp_idle", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        checkValue("pu_rd_a", PU_WDATA);
        checkOutput();
        checkValue("pu_rd_b", PU_WDATA);
        checkOutput();
        checkValue("pu_rd_unwritten", 8'h00);
        checkOutput();
        checkOutput();

        // Repeat count with a pause window; pause in IDLE is ignored
        writeWord(0, mkWord(1, 5, 0, 1, 2));
        applyStimulus(0, 1, 0);
        pushExp("pause_idle", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(1, 0, 0);
        pushExp("rp_c1", 2, 1, 0, 1, 0, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        pushExp("rp_c2", 2, 1, 0, 1, 0, 0, 0);
        checkOutput();
        applyStimulus(0, 1, 0);
        for (int i = 0; i < 3; i++) pushExp("rp_paused", 2, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) checkOutput();
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 4; i++) pushExp("rp_resumed", 2, 1, 0, 1, 0, 0, 0);
        pushExp("rp_done", 0, 0, 0, 0, 1, 0, 0);
        pushExp("rp_idle", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) checkOutput();

        // Looping two-word program, start while busy, then abort
        bus.loop_en = 1'b1;
        writeWord(0, mkWord(0, 0, 1, 0, 7));
        writeWord(1, mkWord(1, 0, 0, 1, 8));
        applyStimulus(1, 0, 0);
        pushExp("lp_pc0", 7, 0, 1, 1, 0, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        pushExp("lp_pc1", 8, 1, 0, 1, 0, 1, 0);
        checkOutput();
        applyStimulus(1, 0, 0);
        pushExp("lp_wrap_busy_start", 7, 0, 1, 1, 0, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        pushExp("lp_pc1_b", 8, 1, 0, 1, 0, 1, 0);
        pushExp("lp_pc0_b", 7, 0, 1, 1, 0, 0, 0);
        checkOutput();
        checkOutput();
        applyStimulus(0, 0, 1);
        pushExp("abort", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        pushExp("abort_after", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(1, 0, 1);
        pushExp("start_abort", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        pushExp("start_abort_after", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        bus.loop_en = 1'b0;

        // Program write while busy is dropped and flagged
        writeWord(0, mkWord(1, 3, 0, 1, 9));
        applyStimulus(1, 0, 0);
        pushExp("we_run", 9, 1, 0, 1, 0, 0, 0);
        checkOutput();
        bus.prog_we   = 1'b1;
        bus.prog_addr = 0;
        bus.prog_data = mkWord(1, 0, 1, 0, 4);
        applyStimulus(0, 0, 0);
        pushExp("we_err_set", 9, 1, 0, 1, 0, 0, 1);
        checkOutput();
        bus.prog_we = 1'b0;
        pushExp("we_rep1", 9, 1, 0, 1, 0, 0, 1);
        pushExp("we_rep0", 9, 1, 0, 1, 0, 0, 1);
        pushExp("we_done", 0, 0, 0, 0, 1, 0, 1);
        pushExp("we_err_sticky", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) checkOutput();
        applyStimulus(1, 0, 0);
        pushExp("we_restart_clear", 9, 1, 0, 1, 0, 0, 0);
        checkOutput();

        // Asynchronous reset in the middle of a word
        applyStimulus(0, 0, 0);
        pushExp("ar_run", 9, 1, 0, 1, 0, 0, 0);
        checkOutput();
        #3;
        dp_rst_n = 1'b0;
        #1;
        pushExp("ar_immediate", 0, 0, 0, 0, 0, 0, 0);
        compareNow();
        @(negedge dp_clk);
        dp_rst_n = 1'b1;
        pushExp("ar_idle0", 0, 0, 0, 0, 0, 0, 0);
        pushExp("ar_idle1", 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        checkOutput();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL sb_drain observed=%0d entries expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
